// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer between two masters and one single-port data memory.
// Each transaction is IDLE (grant and latch) -> ACCESS (one memory strobe) -> RESP (done pulse).
module dmem_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             done0,
  output logic             done1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             port_q, port_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             win;
  logic [WIDTH-1:0] win_addr;

  // On a tie the port that was not granted last wins; ptr_q holds the last grant.
  always_comb begin
    win = req1;
    if (req0 && req1) begin
      win = ~ptr_q;
    end
    win_addr = win ? addr1 : addr0;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    port_d  = port_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCESS;
          ptr_d   = win;
          port_d  = win;
          we_d    = win ? we1 : we0;
          addr_d  = win_addr;
          wdata_d = win ? wdata1 : wdata0;
          err_d   = (win_addr >= DEPTH_W);
        end
      end
      ACCESS: begin
        state_d = RESP;
        // Writes and rejected accesses report zero read data.
        if (!we_q && !err_q) begin
          rdata_d = mem_rdata;
        end else begin
          rdata_d = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      port_q  <= port_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done0     = (state_q == RESP) && !port_q;
  assign done1     = (state_q == RESP) && port_q;
  assign err0      = done0 && err_q;
  assign err1      = done1 && err_q;
  assign rdata     = rdata_q;
  assign mem_read  = (state_q == ACCESS) && !err_q && !we_q;
  assign mem_write = (state_q == ACCESS) && !err_q && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural memory, expected-response queue,
// latency/order checks per transaction and protocol invariants checked every cycle.
module tb_dmem_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 512;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, we0, req1, we1;
  logic [WIDTH-1:0] addr0, wdata0, addr1, wdata1;
  logic             done0, done1, err0, err1, busy;
  logic             mem_read, mem_write;
  logic [WIDTH-1:0] rdata, mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata(rdata), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on rising edge.
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  assign mem_rdata = mem[mem_addr[8:0]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[8:0]] <= mem_wdata;
  end

  typedef struct packed {
    logic             port;
    logic             err;
    logic [WIDTH-1:0] rdata;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] shadow [0:DEPTH-1];
  int               checks = 0;
  int               errors = 0;
  int               write_cnt = 0;
  exp_t             mon_e;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic p, input logic w, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] d);
    exp_t e;
    e.port  = p;
    e.err   = (a >= DEPTH);
    e.rdata = '0;
    if (!e.err) begin
      if (w) shadow[a[8:0]] = d;
      else   e.rdata = shadow[a[8:0]];
    end
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic p, input logic r, input logic w,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] d);
    if (p) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  // Called at posedge+1 with the expected response already queued.
  // Holds req until done, optionally holds one extra IDLE cycle (second transaction).
  task automatic run_txn(input logic p, input logic w, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] d, input int exp_lat, input bit extra);
    int n;
    drive(p, 1'b1, w, a, d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p ? done1 : done0) && n < 30);
    check_val(p ? "latency_p1" : "latency_p0", 64'(n), 64'(exp_lat));
    if (extra) begin
      push_exp(p, w, a, d);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(p ? done1 : done0) && n < 30);
      check_val("holdoff_latency", 64'(n), 64'd3);
    end
    @(posedge clk);
    #1;
    drive(p, 1'b0, w, a, d);
  endtask

  task automatic txn(input logic p, input logic w, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] d);
    push_exp(p, w, a, d);
    run_txn(p, w, a, d, 3, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ctrl"}, 64'({done0, done1, err0, err1, busy, mem_read, mem_write}), 64'd0);
    check_val({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check_val({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    check_val({tag, "_rdata"}, 64'(rdata), 64'd0);
  endtask

  // Scoreboard and invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (done0 || done1) begin
        check_val("done_onehot", 64'(done0 & done1), 64'd0);
        check_val("unexpected_done", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check_val("done_port", 64'(done1), 64'(mon_e.port));
          check_val("err_flag", 64'(done1 ? err1 : err0), 64'(mon_e.err));
          check_val("rdata", 64'(rdata), 64'(mon_e.rdata));
        end
      end
      if (err0 || err1) begin
        check_val("err_without_done", 64'((err0 & ~done0) | (err1 & ~done1)), 64'd0);
      end
      if (mem_read || mem_write) begin
        check_val("strobe_in_access", 64'({busy, done0 | done1}), 64'd2);
      end
      if (mem_write) write_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int wc;
    int n;
    int cnt;
    int last_n;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Preload through the DUT.
    txn(1'b0, 1'b1, 32'd0,   32'hA5A5_A5A5);
    txn(1'b1, 1'b1, 32'd10,  32'h1010_1010);
    txn(1'b0, 1'b1, 32'd20,  32'h2020_2020);
    txn(1'b1, 1'b1, 32'd511, 32'h5115_1151);

    // Write then read on port 0.
    wc = write_cnt;
    txn(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    check_val("write_strobe_count", 64'(write_cnt - wc), 64'd1);
    check_val("mem5", 64'(mem[5]), 64'hDEAD_BEEF);
    txn(1'b0, 1'b0, 32'd5, 32'd0);

    // Simultaneous requests straight after reset.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp(1'b0, 1'b0, 32'd1, 32'd0);
    push_exp(1'b1, 1'b1, 32'd2, 32'h1234_5678);
    fork
      run_txn(1'b0, 1'b0, 32'd1, 32'd0, 3, 1'b0);
      run_txn(1'b1, 1'b1, 32'd2, 32'h1234_5678, 6, 1'b0);
    join
    check_val("mem2", 64'(mem[2]), 64'h1234_5678);

    // Continuous contention for 12 cycles: port 0 granted first.
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b0, 1'b0, 32'd10, 32'd0);
      push_exp(1'b1, 1'b0, 32'd20, 32'd0);
    end
    drive(1'b0, 1'b1, 1'b0, 32'd10, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd20, 32'd0);
    cnt = 0;
    last_n = 0;
    for (n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (done0 || done1) begin
        check_val("cont_port", 64'(done1), 64'(cnt % 2));
        check_val("cont_gap", 64'(n - last_n), 64'd3);
        last_n = n;
        cnt++;
      end
    end
    check_val("cont_count", 64'(cnt), 64'd4);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 32'd10, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd20, 32'd0);

    // Out of range write, then the last valid word.
    wc = write_cnt;
    txn(1'b1, 1'b1, 32'd512, 32'hFFFF_FFFF);
    check_val("oor_no_write", 64'(write_cnt - wc), 64'd0);
    check_val("oor_mem0", 64'(mem[0]), 64'hA5A5_A5A5);
    txn(1'b1, 1'b0, 32'd511, 32'd0);

    // Reset during the ACCESS of a read, then a tie.
    drive(1'b0, 1'b1, 1'b0, 32'd10, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd10, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk);
    #1;
    push_exp(1'b0, 1'b0, 32'd20, 32'd0);
    push_exp(1'b1, 1'b0, 32'd10, 32'd0);
    fork
      run_txn(1'b0, 1'b0, 32'd20, 32'd0, 3, 1'b0);
      run_txn(1'b1, 1'b0, 32'd10, 32'd0, 6, 1'b0);
    join

    // Requester holds req one cycle past done: second identical transaction.
    push_exp(1'b0, 1'b0, 32'd5, 32'd0);
    run_txn(1'b0, 1'b0, 32'd5, 32'd0, 3, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester round-robin arbiter and access sequencer for the single-port data memory. It sits between the CPU load/store stage (port 0) and a DMA/debug master (port 1) on one side, and the data memory's MemRead/MemWrite/Address/WriteData/ReadData pins on the other. It serialises accesses, range-checks addresses, and returns registered read data with a one-cycle done pulse per transaction.

## Interface
- WIDTH, 32, data and address width
- DEPTH, 512, number of memory words; valid word addresses are 0..DEPTH-1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req0 / req1  in  1  access request, level, per port
- we0 / we1  in  1  1 = write, 0 = read; held with req
- addr0 / addr1  in  WIDTH  word address; held with req
- wdata0 / wdata1  in  WIDTH  write data; held with req
- done0 / done1  out  1  one-cycle completion pulse
- err0 / err1  out  1  valid only with done: address out of range
- rdata  out  WIDTH  registered read data; valid with done0/done1 on a read
- busy  out  1  high when state is not IDLE
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_addr  out  WIDTH  to memory Address
- mem_wdata  out  WIDTH  to memory WriteData
- mem_rdata  in  WIDTH  from memory ReadData (combinational read)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if neither req is high, stay. Otherwise pick a winner, latch its we/addr/wdata and its port id into internal registers, compute range_err = (addr >= DEPTH), then go to ACCESS.
- Arbitration: single requester always wins. If both are requesting, the port not granted last wins. The last-grant pointer updates on every IDLE->ACCESS transition. After reset the pointer = 1, so port 0 wins the first tie.
- ACCESS (exactly one cycle): mem_addr = latched addr, mem_wdata = latched wdata.
  - No range_err: mem_write = latched we, mem_read = !latched we.
  - range_err: both strobes stay 0 and memory is untouched.
  - Writes commit to memory at the rising edge ending ACCESS.
  - On a read without error, mem_rdata is captured into rdata at that same edge.
  - Next state is RESP.
- RESP (exactly one cycle): assert done of the latched port and err = range_err. rdata holds the captured word on a read; it is 0 on a write or an error. Next state is IDLE. No request is sampled in RESP.
- Outside ACCESS: mem_read = mem_write = 0. mem_addr and mem_wdata hold their last latched values.
- Requester rule: hold req, we, addr and wdata stable from assertion until done is seen. Drop req at the edge that ends the done cycle. A req still high in the following IDLE cycle is a new transaction.
- The loser's req is never dropped by the arbiter. It is served on the next IDLE pass.
- rdata holds its value until the next RESP.
- Reset: on the edge where rst = 1, the state goes to IDLE and the pointer goes to 1.
  - All outputs become 0: done0, done1, err0, err1, busy, mem_read, mem_write, mem_addr, mem_wdata, rdata.
  - Reset in ACCESS suppresses the strobes from the next cycle. A write whose edge coincides with rst is still committed by the memory; the transaction is otherwise abandoned with no done.
  - Reset in RESP cancels the done pulse.

## Timing
- Latency: req sampled high in IDLE cycle N, then ACCESS in N+1, then done/rdata in N+2.
- Throughput: one transaction per 3 cycles. With both ports requesting continuously, grants alternate 0,1,0,1 and each port completes one access every 6 cycles.
- busy is high in ACCESS and RESP, and low in IDLE.
- Only one of done0/done1 is ever high in a cycle. err is never high without its done.
- Range check is unsigned, full WIDTH: addr = DEPTH-1 is valid and addr = DEPTH is an error.

## Test plan
- Write then read, port 0:
  - Stimulus: write 0xDEADBEEF to addr 5, then read addr 5.
  - Required: mem_write high only in the ACCESS cycle; done0 two cycles after req; read returns rdata = 0xDEADBEEF with err0 = 0.
- Simultaneous requests from idle after reset:
  - Stimulus: port 0 reads addr 1 and port 1 writes 0x12345678 to addr 2, both in the same cycle.
  - Required: port 0 is served first, with done0 at N+2; port 1 is served next, with done1 at N+5; memory[2] = 0x12345678.
- Continuous contention:
  - Stimulus: both ports hold req (re-asserting after each done) for 12 cycles.
  - Required: done pulses alternate 0,1,0,1, one every 3 cycles; no port starves.
- Out-of-range:
  - Stimulus: port 1 writes 0xFFFFFFFF to addr 512, then reads addr 511.
  - Required: the first transaction gives done1 with err1 = 1, mem_write never high, and memory unchanged. The second gives err1 = 0 with normal rdata.
- Reset mid-transaction:
  - Stimulus: assert rst during the ACCESS of a read.
  - Required: no done pulse; all outputs 0 on the following cycle; a subsequent tie is granted to port 0.
- Hold-off rule:
  - Stimulus: port 0 keeps req high for one extra cycle after done0.
  - Required: a second identical transaction is issued, with done0 again 3 cycles later.
